// File: rtl/hzd_ctrl_mw_pkg.sv
// Shared encodings for the M/W hazard controller: result classes, forward selects,
// Tuse codes and the Tnew lookup used by the stall logic.
package hzd_ctrl_mw_pkg;

  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC  = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_PIPE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  localparam logic [1:0] USE_D    = 2'd0;
  localparam logic [1:0] USE_E    = 2'd1;
  localparam logic [1:0] USE_M    = 2'd2;
  localparam logic [1:0] USE_NONE = 2'd3;

  localparam logic [1:0] MDOP_NONE = 2'd0;
  localparam logic [1:0] MDOP_MULT = 2'd1;
  localparam logic [1:0] MDOP_DIV  = 2'd2;

  typedef enum logic [1:0] {
    STG_E = 2'd0,
    STG_M = 2'd1,
    STG_W = 2'd2
  } stage_t;

  // Cycles until a result of class res is available, counted from the given stage.
  function automatic logic [1:0] tnew(input logic [2:0] res, input stage_t stg);
    logic [1:0] t;
    t = 2'd0;
    case (stg)
      STG_E: begin
        case (res)
          RES_ALU: t = 2'd1;
          RES_DM:  t = 2'd2;
          RES_MD:  t = 2'd1;
          default: t = 2'd0;
        endcase
      end
      STG_M:   t = (res == RES_DM) ? 2'd1 : 2'd0;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/hzd_ctrl_mw_md_busy_cnt.sv
// Mult/div occupancy counter: loads on an E-stage start while idle, counts down to zero.
module md_busy_cnt
  import hzd_ctrl_mw_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] mdop,
  output logic       mdbusy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  logic [3:0] cnt;

  // A start seen while the counter is running is ignored, not queued.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= 4'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else if (mdop == MDOP_MULT) begin
      cnt <= MULT_LD;
    end else if (mdop == MDOP_DIV) begin
      cnt <= DIV_LD;
    end
  end

  assign mdbusy = (cnt != 4'd0);

endmodule

// File: rtl/hzd_ctrl_mw.sv
// Hazard controller for the 5-stage MIPS pipe: owns the M/W tag registers, produces
// the D-stage stall, E-stage bubble clear and every forwarding select.
module hzd_ctrl_mw
  import hzd_ctrl_mw_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DEMWclr,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic [1:0] use1D,
  input  logic [1:0] use2D,
  input  logic       mdD,
  input  logic [4:0] ra1E,
  input  logic [4:0] ra2E,
  input  logic [4:0] waE,
  input  logic [2:0] resE,
  input  logic [1:0] mdopE,
  output logic       stallD,
  output logic       Eclr,
  output logic [1:0] fwd1D,
  output logic [1:0] fwd2D,
  output logic [1:0] fwd1E,
  output logic [1:0] fwd2E,
  output logic       fwd2M,
  output logic [4:0] waM,
  output logic [2:0] resM,
  output logic [4:0] waW,
  output logic [2:0] resW,
  output logic       mdbusy
);

  logic [4:0] ra2M;
  logic       raw_stall;
  logic       md_stall;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] wa, input logic [2:0] res);
    return (r != 5'd0) && (r == wa) && (res != RES_NW);
  endfunction

  function automatic logic need_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input logic [4:0] wa_e, input logic [2:0] res_e,
                                      input logic [4:0] wa_m, input logic [2:0] res_m);
    return (tuse != USE_NONE) &&
           ((hit(r, wa_e, res_e) && (tnew(res_e, STG_E) > tuse)) ||
            (hit(r, wa_m, res_m) && (tnew(res_m, STG_M) > tuse)));
  endfunction

  // Only a PC result (jal link) is ready in E; DM is never ready in M for D.
  function automatic logic [1:0] sel_d(input logic [4:0] r,
                                       input logic [4:0] wa_e, input logic [2:0] res_e,
                                       input logic [4:0] wa_m, input logic [2:0] res_m,
                                       input logic [4:0] wa_w, input logic [2:0] res_w);
    logic [1:0] s;
    s = FWD_RF;
    if (hit(r, wa_e, res_e) && (res_e == RES_PC)) begin
      s = FWD_E;
    end else if (hit(r, wa_m, res_m) &&
                 ((res_m == RES_ALU) || (res_m == RES_PC) || (res_m == RES_MD))) begin
      s = FWD_M;
    end else if (hit(r, wa_w, res_w)) begin
      s = FWD_W;
    end
    return s;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] r,
                                       input logic [4:0] wa_m, input logic [2:0] res_m,
                                       input logic [4:0] wa_w, input logic [2:0] res_w);
    logic [1:0] s;
    s = FWD_PIPE;
    if (hit(r, wa_m, res_m) && (res_m != RES_DM)) begin
      s = FWD_M;
    end else if (hit(r, wa_w, res_w)) begin
      s = FWD_W;
    end
    return s;
  endfunction

  // M and W advance every cycle regardless of the D-stage stall.
  always_ff @(posedge clk) begin
    if (!rst || DEMWclr) begin
      ra2M <= 5'd0;
      waM  <= 5'd0;
      resM <= RES_NW;
      waW  <= 5'd0;
      resW <= RES_NW;
    end else begin
      ra2M <= ra2E;
      waM  <= waE;
      resM <= resE;
      waW  <= waM;
      resW <= resM;
    end
  end

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (DEMWclr),
    .mdop   (mdopE),
    .mdbusy (mdbusy)
  );

  always_comb begin
    raw_stall = need_stall(ra1D, use1D, waE, resE, waM, resM) ||
                need_stall(ra2D, use2D, waE, resE, waM, resM);
    md_stall  = mdD && (mdbusy || (mdopE != MDOP_NONE));
    stallD    = raw_stall || md_stall;
    Eclr      = stallD;
    fwd1D     = sel_d(ra1D, waE, resE, waM, resM, waW, resW);
    fwd2D     = sel_d(ra2D, waE, resE, waM, resM, waW, resW);
    fwd1E     = sel_e(ra1E, waM, resM, waW, resW);
    fwd2E     = sel_e(ra2E, waM, resM, waW, resW);
    fwd2M     = hit(ra2M, waW, resW);
  end

endmodule

// File: doc/hzd_ctrl_mw.md
Name: hzd_ctrl_mw

Overview:
- Hazard controller for the 5-stage MIPS pipeline; sits directly downstream of the E-stage hazard-tag register.
- Consumes E-stage tags: ra1E, ra2E, waE, resE.
- Owns the M- and W-stage tag registers, tracks mult/div unit occupancy with a busy counter, and emits the D-stage stall, the E-stage bubble clear, and all forwarding selects.

Parameters:
MULT_CYC, 5, busy cycles started by mult/multu in E
DIV_CYC, 10, busy cycles started by div/divu in E

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
DEMWclr  in  1  exception flush; clears M/W tags, same cycle semantics as reset
ra1D  in  5  rs index of instruction in D
ra2D  in  5  rt index of instruction in D
use1D  in  2  Tuse of rs: 0=D, 1=E, 2=M, 3=not read
use2D  in  2  Tuse of rt, same encoding
mdD  in  1  D instruction is a mult/div/mfhi/mflo/mthi/mtlo
ra1E  in  5  E-stage rs tag
ra2E  in  5  E-stage rt tag
waE  in  5  E-stage write register
resE  in  3  E-stage result class
mdopE  in  2  0=none, 1=mult start, 2=div start
stallD  out  1  freeze PC and the D register
Eclr  out  1  insert bubble into the E tag/data registers
fwd1D  out  2  rs source for D: 0=RF, 1=E, 2=M, 3=W
fwd2D  out  2  rt source for D
fwd1E  out  2  rs source for E: 0=pipe, 2=M, 3=W
fwd2E  out  2  rt source for E
fwd2M  out  1  store-data source for M: 1=W
waM, resM, waW, resW  out  5/3/5/3  registered tags
mdbusy  out  1  busy counter nonzero

Behaviour:
- Result classes, 3 bits: NW=0, ALU=1, DM=2, PC=3, MD=4.
- Registers ra2M, waM, resM, waW, resW, cnt:
  - On posedge clk, if !rst or DEMWclr, all clear to 0.
  - Otherwise M <= E tags and W <= M tags.
  - Each stage advances every cycle; stall does not hold M/W.
- Tnew:
  - In E: ALU=1, DM=2, PC=0, MD=1, NW=0.
  - In M: DM=1, else 0.
  - In W: 0.
- Match condition for stage X and read index r: r != 0 && r == waX && resX != NW.
- Stall condition: a D read with use != 3 matches E and Tnew_E > use, or matches M and Tnew_M > use.
- MD stall: mdD && (mdbusy || mdopE != 0).
- Outputs: stallD = either condition; Eclr = stallD. Both are combinational.
- fwd1D/fwd2D priority: E (only if resE == PC), then M (resM in {ALU, PC, MD}), then W (any match), else 0.
- fwd1E/fwd2E: check M first (resM != DM), then W, else 0.
  - A DM match in M is never forwarded to E; the stall logic already prevents that case.
- fwd2M: 1 when ra2M matches W.
- Register 0 never forwards and never stalls.
- Busy counter cnt, 4 bits:
  - When cnt == 0 and mdopE == 1, load MULT_CYC; when cnt == 0 and mdopE == 2, load DIV_CYC.
  - When cnt != 0, decrement each cycle and ignore mdopE.
  - mdbusy = (cnt != 0).
- Reset values: every registered tag = 0, cnt = 0, so stallD = 0 and all fwd = 0 after reset.
- Reset or DEMWclr mid-count: cnt is forced to 0, which aborts the busy window.
- When reset and advance coincide, reset wins.

Decomposition:
- Shared package: result-class constants (NW/ALU/DM/PC/MD), fwd select encodings, Tuse encodings, and a Tnew lookup function indexed by class and stage.
- Natural sub-module: md_busy_cnt (counter + mdbusy), parameterised by MULT_CYC and DIV_CYC.
- The rest is flat: the tag registers plus combinational compare logic.

Test Plan:
- Load-use:
  - E holds lw $8 (waE=8, resE=DM) and D has add reading rs=8 with use1D=1 → stallD=1, Eclr=1.
  - Next cycle, M holds lw: stallD=0, fwd1E=3 once lw reaches W.
- ALU-to-branch:
  - E holds addu $9 (resE=ALU) and D has beq reading $9 with use=0 → stall 1 cycle.
  - Next cycle → stallD=0, fwd1D=2.
- jal forward: E holds jal (waE=31, resE=PC) and D has jr $31 with use=0 → stallD=0, fwd1D=1.
- $0 write: waE=0, resE=ALU, D reads ra1D=0 with use=0 → stallD=0, fwd1D=0.
- Divider:
  - mdopE=2 → mdbusy=1 for exactly 10 cycles.
  - mfhi in D during that window → stallD=1; clears the cycle cnt reaches 0.
  - DEMWclr asserted at cycle 4 → mdbusy=0 the next cycle.
- Reset: drive rst=0 for 1 cycle with tags loaded → waM=resM=waW=resW=0, all fwd=0, stallD=0.
